// File: rtl/bus_axi_bridge.sv
// ---------------------------------------------------------------------------
// bus_axi_bridge
//
// Purpose:
//   Bridges a simple Avalon-style slave bus (read/write strobes with
//   waitrequest) onto an AXI4 master port. Only one transaction is in flight
//   at a time, and every AXI transaction is a single-beat INCR burst.
//   A response-wait timeout keeps the slave bus from locking up when the
//   AXI side never answers.
//
// Parameters:
//   ADDR_W  - address width
//   DATA_W  - data width (32, 64 or 128)
//   ID_W    - AXI ID width
//   AXI_ID  - ID driven on awid/arid and required on bid/rid
//   TIMEOUT - response-wait limit in cycles, 0 disables the timeout
//
// Ports:
//   clk, rst_n             - clock (rising edge), async active-low reset
//   slv_bus_*              - slave-side request/response bus
//   mst_axi_aw* / mst_axi_w*  - AXI write address / write data channels
//   mst_axi_b*             - AXI write response channel
//   mst_axi_ar* / mst_axi_r*  - AXI read address / read data channels
// ---------------------------------------------------------------------------
module bus_axi_bridge #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int ID_W    = 4,
  parameter int AXI_ID  = 0,
  parameter int TIMEOUT = 1023
) (
  input  logic                clk,
  input  logic                rst_n,

  input  logic [ADDR_W-1:0]   slv_bus_addr,
  input  logic                slv_bus_read,
  input  logic                slv_bus_write,
  input  logic [DATA_W-1:0]   slv_bus_writedata,
  input  logic [DATA_W/8-1:0] slv_bus_byteenable,
  output logic [DATA_W-1:0]   slv_bus_readdata,
  output logic [1:0]          slv_bus_response,
  output logic                slv_bus_waitrequest,

  output logic [ID_W-1:0]     mst_axi_awid,
  output logic [ADDR_W-1:0]   mst_axi_awaddr,
  output logic [7:0]          mst_axi_awlen,
  output logic [2:0]          mst_axi_awsize,
  output logic [1:0]          mst_axi_awburst,
  output logic                mst_axi_awlock,
  output logic [3:0]          mst_axi_awcache,
  output logic [2:0]          mst_axi_awprot,
  output logic [3:0]          mst_axi_awqos,
  output logic                mst_axi_awvalid,
  input  logic                mst_axi_awready,

  output logic [DATA_W-1:0]   mst_axi_wdata,
  output logic [DATA_W/8-1:0] mst_axi_wstrb,
  output logic                mst_axi_wlast,
  output logic                mst_axi_wvalid,
  input  logic                mst_axi_wready,

  input  logic [ID_W-1:0]     mst_axi_bid,
  input  logic [1:0]          mst_axi_bresp,
  input  logic                mst_axi_bvalid,
  output logic                mst_axi_bready,

  output logic [ID_W-1:0]     mst_axi_arid,
  output logic [ADDR_W-1:0]   mst_axi_araddr,
  output logic [7:0]          mst_axi_arlen,
  output logic [2:0]          mst_axi_arsize,
  output logic [1:0]          mst_axi_arburst,
  output logic                mst_axi_arlock,
  output logic [3:0]          mst_axi_arcache,
  output logic [2:0]          mst_axi_arprot,
  output logic [3:0]          mst_axi_arqos,
  output logic                mst_axi_arvalid,
  input  logic                mst_axi_arready,

  input  logic [ID_W-1:0]     mst_axi_rid,
  input  logic [DATA_W-1:0]   mst_axi_rdata,
  input  logic [1:0]          mst_axi_rresp,
  input  logic                mst_axi_rlast,
  input  logic                mst_axi_rvalid,
  output logic                mst_axi_rready
);

  localparam logic [ID_W-1:0] ID_VAL  = ID_W'(AXI_ID);
  localparam logic [2:0]      AX_SIZE = 3'($clog2(DATA_W/8));
  localparam int              CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TMO_VAL = CNT_W'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE,
    WADDR,
    WRESP,
    RADDR,
    RDATA,
    DONE
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W/8-1:0]   wstrb_q, wstrb_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  arvalid_q, arvalid_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_W-1:0]     readdata_q, readdata_d;
  logic [1:0]            resp_q, resp_d;
  logic                  abandon_q, abandon_d;

  logic                  req;
  logic                  busy;
  logic                  keep_result;
  logic                  timeout_hit;

  assign req  = slv_bus_read | slv_bus_write;
  assign busy = (state_q == WADDR) || (state_q == WRESP) ||
                (state_q == RADDR) || (state_q == RDATA);

  // A result is only published if the master has held its request for the
  // whole transaction; otherwise the AXI side finishes but the answer is lost.
  assign keep_result = req & ~abandon_q;

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TMO_VAL);

  // Constant AXI sideband: single-beat INCR bursts of full bus width.
  assign mst_axi_awid    = ID_VAL;
  assign mst_axi_awlen   = 8'd0;
  assign mst_axi_awsize  = AX_SIZE;
  assign mst_axi_awburst = 2'b01;
  assign mst_axi_awlock  = 1'b0;
  assign mst_axi_awcache = 4'd0;
  assign mst_axi_awprot  = 3'd0;
  assign mst_axi_awqos   = 4'd0;
  assign mst_axi_arid    = ID_VAL;
  assign mst_axi_arlen   = 8'd0;
  assign mst_axi_arsize  = AX_SIZE;
  assign mst_axi_arburst = 2'b01;
  assign mst_axi_arlock  = 1'b0;
  assign mst_axi_arcache = 4'd0;
  assign mst_axi_arprot  = 3'd0;
  assign mst_axi_arqos   = 4'd0;
  assign mst_axi_wlast   = 1'b1;

  // Address and data come straight from the captured registers, which only
  // change in IDLE, so they are stable for as long as any valid is high.
  assign mst_axi_awaddr  = addr_q;
  assign mst_axi_araddr  = addr_q;
  assign mst_axi_wdata   = wdata_q;
  assign mst_axi_wstrb   = wstrb_q;
  assign mst_axi_awvalid = awvalid_q;
  assign mst_axi_wvalid  = wvalid_q;
  assign mst_axi_arvalid = arvalid_q;

  // Response channels are also open in IDLE so stray or late beats drain.
  assign mst_axi_bready  = (state_q == WRESP) || (state_q == IDLE);
  assign mst_axi_rready  = (state_q == RDATA) || (state_q == IDLE);

  assign slv_bus_readdata    = readdata_q;
  assign slv_bus_response    = resp_q;
  assign slv_bus_waitrequest = req & (state_q != DONE);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    awvalid_d  = awvalid_q;
    wvalid_d   = wvalid_q;
    arvalid_d  = arvalid_q;
    cnt_d      = cnt_q;
    readdata_d = readdata_q;
    resp_d     = resp_q;
    abandon_d  = abandon_q;

    case (state_q)
      IDLE: begin
        cnt_d     = '0;
        abandon_d = 1'b0;
        if (slv_bus_write) begin
          addr_d    = slv_bus_addr;
          wdata_d   = slv_bus_writedata;
          wstrb_d   = slv_bus_byteenable;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          state_d   = WADDR;
        end else if (slv_bus_read) begin
          addr_d    = slv_bus_addr;
          wdata_d   = slv_bus_writedata;
          wstrb_d   = slv_bus_byteenable;
          arvalid_d = 1'b1;
          state_d   = RADDR;
        end
      end

      WADDR: begin
        // AW and W complete independently; a channel whose valid is already
        // low has finished its handshake earlier.
        if (awvalid_q && mst_axi_awready) begin
          awvalid_d = 1'b0;
        end
        if (wvalid_q && mst_axi_wready) begin
          wvalid_d = 1'b0;
        end
        if ((!awvalid_q || mst_axi_awready) && (!wvalid_q || mst_axi_wready)) begin
          state_d = WRESP;
        end
      end

      WRESP: begin
        if (mst_axi_bvalid && (mst_axi_bid == ID_VAL)) begin
          if (keep_result) begin
            resp_d = mst_axi_bresp;
          end
          state_d = DONE;
        end
      end

      RADDR: begin
        if (mst_axi_arready) begin
          arvalid_d = 1'b0;
          state_d   = RDATA;
        end
      end

      RDATA: begin
        if (mst_axi_rvalid && mst_axi_rlast && (mst_axi_rid == ID_VAL)) begin
          if (keep_result) begin
            readdata_d = mst_axi_rdata;
            resp_d     = mst_axi_rresp;
          end
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Timeout supervision overrides whatever the busy state decided above.
    if (busy) begin
      cnt_d     = cnt_q + CNT_W'(1);
      abandon_d = abandon_q | ~req;
      if (timeout_hit) begin
        state_d   = DONE;
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        arvalid_d = 1'b0;
        if (keep_result) begin
          readdata_d = '0;
          resp_d     = 2'b11;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      arvalid_q  <= 1'b0;
      cnt_q      <= '0;
      readdata_q <= '0;
      resp_q     <= 2'b00;
      abandon_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      arvalid_q  <= arvalid_d;
      cnt_q      <= cnt_d;
      readdata_q <= readdata_d;
      resp_q     <= resp_d;
      abandon_q  <= abandon_d;
    end
  end

endmodule

// File: tb/tb_bus_axi_bridge.sv
// ---------------------------------------------------------------------------
// tb_bus_axi_bridge
//
// Directed bench for bus_axi_bridge with TIMEOUT = 8. Inputs are driven and
// outputs sampled on the falling clock edge; the AXI slave side is driven
// by hand inside the single stimulus sequence.
// ---------------------------------------------------------------------------
module tb_bus_axi_bridge;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int ID_W   = 4;

  logic                clk;
  logic                rst_n;
  logic [ADDR_W-1:0]   slvAddr;
  logic                slvRead;
  logic                slvWrite;
  logic [DATA_W-1:0]   slvWriteData;
  logic [DATA_W/8-1:0] slvByteEnable;
  logic [DATA_W-1:0]   slvReadData;
  logic [1:0]          slvResponse;
  logic                slvWaitRequest;

  logic [ID_W-1:0]     awId;
  logic [ADDR_W-1:0]   awAddr;
  logic [7:0]          awLen;
  logic [2:0]          awSize;
  logic [1:0]          awBurst;
  logic                awLock;
  logic [3:0]          awCache;
  logic [2:0]          awProt;
  logic [3:0]          awQos;
  logic                awValid;
  logic                awReady;
  logic [DATA_W-1:0]   wData;
  logic [DATA_W/8-1:0] wStrb;
  logic                wLast;
  logic                wValid;
  logic                wReady;
  logic [ID_W-1:0]     bId;
  logic [1:0]          bResp;
  logic                bValid;
  logic                bReady;
  logic [ID_W-1:0]     arId;
  logic [ADDR_W-1:0]   arAddr;
  logic [7:0]          arLen;
  logic [2:0]          arSize;
  logic [1:0]          arBurst;
  logic                arLock;
  logic [3:0]          arCache;
  logic [2:0]          arProt;
  logic [3:0]          arQos;
  logic                arValid;
  logic                arReady;
  logic [ID_W-1:0]     rId;
  logic [DATA_W-1:0]   rData;
  logic [1:0]          rResp;
  logic                rLast;
  logic                rValid;
  logic                rReady;

  int checkCount;
  int errorCount;
  int latency;

  bus_axi_bridge #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .ID_W   (ID_W),
    .AXI_ID (0),
    .TIMEOUT(8)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .slv_bus_addr       (slvAddr),
    .slv_bus_read       (slvRead),
    .slv_bus_write      (slvWrite),
    .slv_bus_writedata  (slvWriteData),
    .slv_bus_byteenable (slvByteEnable),
    .slv_bus_readdata   (slvReadData),
    .slv_bus_response   (slvResponse),
    .slv_bus_waitrequest(slvWaitRequest),
    .mst_axi_awid       (awId),
    .mst_axi_awaddr     (awAddr),
    .mst_axi_awlen      (awLen),
    .mst_axi_awsize     (awSize),
    .mst_axi_awburst    (awBurst),
    .mst_axi_awlock     (awLock),
    .mst_axi_awcache    (awCache),
    .mst_axi_awprot     (awProt),
    .mst_axi_awqos      (awQos),
    .mst_axi_awvalid    (awValid),
    .mst_axi_awready    (awReady),
    .mst_axi_wdata      (wData),
    .mst_axi_wstrb      (wStrb),
    .mst_axi_wlast      (wLast),
    .mst_axi_wvalid     (wValid),
    .mst_axi_wready     (wReady),
    .mst_axi_bid        (bId),
    .mst_axi_bresp      (bResp),
    .mst_axi_bvalid     (bValid),
    .mst_axi_bready     (bReady),
    .mst_axi_arid       (arId),
    .mst_axi_araddr     (arAddr),
    .mst_axi_arlen      (arLen),
    .mst_axi_arsize     (arSize),
    .mst_axi_arburst    (arBurst),
    .mst_axi_arlock     (arLock),
    .mst_axi_arcache    (arCache),
    .mst_axi_arprot     (arProt),
    .mst_axi_arqos      (arQos),
    .mst_axi_arvalid    (arValid),
    .mst_axi_arready    (arReady),
    .mst_axi_rid        (rId),
    .mst_axi_rdata      (rData),
    .mst_axi_rresp      (rResp),
    .mst_axi_rlast      (rLast),
    .mst_axi_rvalid     (rValid),
    .mst_axi_rready     (rReady)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one slave-bus request and let combinational outputs settle.
  task automatic applyStimulus(input logic rd, input logic wr,
                               input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] be);
    slvRead       = rd;
    slvWrite      = wr;
    slvAddr       = addr;
    slvWriteData  = data;
    slvByteEnable = be;
    #1;
  endtask

  // One counted comparison; a miss is reported with tag and both values.
  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    checkCount++;
    assert (observed === expected) else begin
      errorCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Count falling edges until waitrequest drops, giving up after budget.
  task automatic waitForWaitLow(input int budget, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (slvWaitRequest && cycles < budget);
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    rst_n   = 1'b0;
    awReady = 1'b1;
    wReady  = 1'b1;
    arReady = 1'b1;
    bId     = '0;
    bResp   = 2'b00;
    bValid  = 1'b0;
    rId     = '0;
    rData   = '0;
    rResp   = 2'b00;
    rLast   = 1'b0;
    rValid  = 1'b0;
    applyStimulus(0, 0, 32'h0, 32'h0, 4'h0);

    // Reset state and constant sideband
    @(negedge clk);
    checkOutput("rst_awvalid", awValid, 1'b0);
    checkOutput("rst_wvalid", wValid, 1'b0);
    checkOutput("rst_arvalid", arValid, 1'b0);
    checkOutput("rst_waitreq", slvWaitRequest, 1'b0);
    checkOutput("rst_readdata", slvReadData, 32'h0);
    checkOutput("rst_response", slvResponse, 2'b00);
    checkOutput("rst_bready", bReady, 1'b1);
    checkOutput("rst_rready", rReady, 1'b1);
    checkOutput("awsize", awSize, 3'd2);
    checkOutput("arsize", arSize, 3'd2);
    checkOutput("awburst", awBurst, 2'b01);
    checkOutput("arlen", arLen, 8'd0);
    checkOutput("wlast", wLast, 1'b1);
    checkOutput("awid", awId, 4'd0);
    applyStimulus(0, 1, 32'h0, 32'h0, 4'h0);
    checkOutput("rst_waitreq_req", slvWaitRequest, 1'b1);
    applyStimulus(0, 0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic write, everything tied ready
    $display("[TB] write 0x1000 with ready and bvalid tied high");
    @(negedge clk);
    bValid = 1'b1;
    applyStimulus(0, 1, 32'h1000, 32'hDEADBEEF, 4'hF);
    checkOutput("w1_wait_idle", slvWaitRequest, 1'b1);
    @(negedge clk);
    checkOutput("w1_awvalid", awValid, 1'b1);
    checkOutput("w1_wvalid", wValid, 1'b1);
    checkOutput("w1_awaddr", awAddr, 32'h1000);
    checkOutput("w1_wdata", wData, 32'hDEADBEEF);
    checkOutput("w1_wstrb", wStrb, 4'hF);
    @(negedge clk);
    checkOutput("w1_awvalid_off", awValid, 1'b0);
    checkOutput("w1_wvalid_off", wValid, 1'b0);
    checkOutput("w1_wait_wresp", slvWaitRequest, 1'b1);
    @(negedge clk);
    checkOutput("w1_wait_done", slvWaitRequest, 1'b0);
    checkOutput("w1_response", slvResponse, 2'b00);
    applyStimulus(0, 0, 32'h0, 32'h0, 4'h0);
    bValid = 1'b0;

    // Write with awready held off for four cycles
    $display("[TB] write with delayed awready");
    @(negedge clk);
    awReady = 1'b0;
    applyStimulus(0, 1, 32'h3008, 32'hCAFEF00D, 4'h3);
    @(negedge clk);
    checkOutput("w2_awvalid_c1", awValid, 1'b1);
    checkOutput("w2_wvalid_c1", wValid, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("w2_awvalid_held", awValid, 1'b1);
      checkOutput("w2_wvalid_dropped", wValid, 1'b0);
      checkOutput("w2_awaddr_stable", awAddr, 32'h3008);
    end
    awReady = 1'b1;
    @(negedge clk);
    checkOutput("w2_awvalid_off", awValid, 1'b0);
    checkOutput("w2_wait_wresp", slvWaitRequest, 1'b1);
    bValid = 1'b1;
    bResp  = 2'b01;
    @(negedge clk);
    checkOutput("w2_wait_done", slvWaitRequest, 1'b0);
    checkOutput("w2_response", slvResponse, 2'b01);
    bValid = 1'b0;
    bResp  = 2'b00;
    applyStimulus(0, 0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    checkOutput("w2_idle_wait", slvWaitRequest, 1'b0);
    checkOutput("w2_response_hold", slvResponse, 2'b01);

    // Read with a slow data beat and SLVERR
    $display("[TB] read 0x2004 with late data");
    applyStimulus(1, 0, 32'h2004, 32'h0, 4'h0);
    @(negedge clk);
    checkOutput("r1_arvalid", arValid, 1'b1);
    checkOutput("r1_araddr", arAddr, 32'h2004);
    checkOutput("r1_awvalid", awValid, 1'b0);
    @(negedge clk);
    checkOutput("r1_arvalid_off", arValid, 1'b0);
    checkOutput("r1_rready", rReady, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("r1_wait_data", slvWaitRequest, 1'b1);
    end
    rValid = 1'b1;
    rLast  = 1'b1;
    rId    = 4'd0;
    rData  = 32'h12345678;
    rResp  = 2'b10;
    @(negedge clk);
    checkOutput("r1_wait_done", slvWaitRequest, 1'b0);
    checkOutput("r1_readdata", slvReadData, 32'h12345678);
    checkOutput("r1_response", slvResponse, 2'b10);
    rValid = 1'b0;
    applyStimulus(0, 0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    checkOutput("r1_readdata_hold", slvReadData, 32'h12345678);

    // Read and write together: write wins
    $display("[TB] simultaneous read and write");
    applyStimulus(1, 1, 32'h4000, 32'h11112222, 4'hF);
    @(negedge clk);
    checkOutput("rw_awvalid", awValid, 1'b1);
    checkOutput("rw_arvalid_c1", arValid, 1'b0);
    @(negedge clk);
    checkOutput("rw_arvalid_c2", arValid, 1'b0);
    bValid = 1'b1;
    @(negedge clk);
    checkOutput("rw_wait_done", slvWaitRequest, 1'b0);
    checkOutput("rw_arvalid_done", arValid, 1'b0);
    checkOutput("rw_response", slvResponse, 2'b00);
    bValid = 1'b0;
    applyStimulus(0, 0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);

    // Read with a foreign-ID beat ahead of the real one
    $display("[TB] read with mismatched rid first");
    applyStimulus(1, 0, 32'h5000, 32'h0, 4'h0);
    @(negedge clk);
    checkOutput("id_arvalid", arValid, 1'b1);
    @(negedge clk);
    rValid = 1'b1;
    rLast  = 1'b1;
    rId    = 4'd3;
    rData  = 32'hBAD0BAD0;
    rResp  = 2'b00;
    @(negedge clk);
    checkOutput("id_wait_discard", slvWaitRequest, 1'b1);
    rId   = 4'd0;
    rData = 32'h0F0F1234;
    @(negedge clk);
    checkOutput("id_wait_done", slvWaitRequest, 1'b0);
    checkOutput("id_readdata", slvReadData, 32'h0F0F1234);
    checkOutput("id_response", slvResponse, 2'b00);
    rValid = 1'b0;
    applyStimulus(0, 0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);

    // Write whose B response never comes: timeout after 8 busy counts
    $display("[TB] write timeout");
    applyStimulus(0, 1, 32'h6000, 32'h55AA55AA, 4'hF);
    waitForWaitLow(20, latency);
    checkOutput("to_latency", latency, 10);
    checkOutput("to_response", slvResponse, 2'b11);
    checkOutput("to_readdata", slvReadData, 32'h0);
    checkOutput("to_awvalid", awValid, 1'b0);
    applyStimulus(0, 0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    bValid = 1'b1;
    #1;
    checkOutput("to_bready_idle", bReady, 1'b1);
    @(negedge clk);
    bValid = 1'b0;
    checkOutput("to_late_wait", slvWaitRequest, 1'b0);
    checkOutput("to_late_response", slvResponse, 2'b11);
    checkOutput("to_late_awvalid", awValid, 1'b0);

    // Request dropped mid-read: AXI finishes, result is not published
    $display("[TB] abandoned read");
    @(negedge clk);
    applyStimulus(1, 0, 32'h7000, 32'h0, 4'h0);
    @(negedge clk);
    checkOutput("ab_arvalid", arValid, 1'b1);
    applyStimulus(0, 0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    checkOutput("ab_arvalid_off", arValid, 1'b0);
    checkOutput("ab_rready", rReady, 1'b1);
    rValid = 1'b1;
    rLast  = 1'b1;
    rId    = 4'd0;
    rData  = 32'hFFFF0000;
    rResp  = 2'b01;
    @(negedge clk);
    rValid = 1'b0;
    checkOutput("ab_readdata", slvReadData, 32'h0);
    checkOutput("ab_response", slvResponse, 2'b11);
    @(negedge clk);

    // Reset in the middle of a write
    $display("[TB] reset mid-transaction");
    awReady = 1'b0;
    applyStimulus(0, 1, 32'h8000, 32'h87654321, 4'hF);
    @(negedge clk);
    checkOutput("mr_awvalid_pre", awValid, 1'b1);
    rst_n = 1'b0;
    #1;
    checkOutput("mr_awvalid_rst", awValid, 1'b0);
    checkOutput("mr_wvalid_rst", wValid, 1'b0);
    checkOutput("mr_response_rst", slvResponse, 2'b00);
    applyStimulus(0, 0, 32'h0, 32'h0, 4'h0);
    awReady = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput("mr_awvalid_after", awValid, 1'b0);
      checkOutput("mr_arvalid_after", arValid, 1'b0);
      checkOutput("mr_wait_after", slvWaitRequest, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/bus_axi_bridge.md
BUS_AXI_BRIDGE -- requirements
Module: bus_axi_bridge

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning data width; legal values are 32, 64 and 128.
REQ-003 SHALL have parameter ID_W, default 4, meaning AXI ID width.
REQ-004 SHALL have parameter AXI_ID, default 0, meaning the ID driven on awid/arid and expected on bid/rid.
REQ-005 SHALL have parameter TIMEOUT, default 1023, meaning the response-wait limit in cycles; 0 disables the timeout.
REQ-006 clk  in  1  clock, all logic on rising edge.
REQ-007 rst_n  in  1  reset, asynchronous, active-low.
REQ-008 slv_bus_addr  in  ADDR_W; slv_bus_read, slv_bus_write  in  1; slv_bus_writedata  in  DATA_W; slv_bus_byteenable  in  DATA_W/8.
REQ-009 slv_bus_readdata  out  DATA_W; slv_bus_response  out  2; slv_bus_waitrequest  out  1.
REQ-010 mst_axi_awid/arid  out  ID_W; mst_axi_awaddr/araddr  out  ADDR_W; mst_axi_awvalid/arvalid  out  1; mst_axi_awready/arready  in  1.
REQ-011 mst_axi_aw*/ar* sideband  out  len 8, size 3, burst 2, lock 1, cache 4, prot 3, qos 4; constant values.
REQ-012 mst_axi_wdata  out  DATA_W; mst_axi_wstrb  out  DATA_W/8; mst_axi_wlast, mst_axi_wvalid  out  1; mst_axi_wready  in  1.
REQ-013 mst_axi_bid  in  ID_W; mst_axi_bresp  in  2; mst_axi_bvalid  in  1; mst_axi_bready  out  1.
REQ-014 mst_axi_rid  in  ID_W; mst_axi_rdata  in  DATA_W; mst_axi_rresp  in  2; mst_axi_rlast, mst_axi_rvalid  in  1; mst_axi_rready  out  1.

Function
REQ-015 Constant outputs SHALL be: id = AXI_ID, len 0, size = log2(DATA_W/8), burst INCR 2'b01, lock/cache/prot/qos 0, wlast 1.
REQ-016 FSM states SHALL be IDLE, WADDR, WRESP, RADDR, RDATA and DONE, with one transaction in flight at a time.
REQ-017 IDLE SHALL move to WADDR on slv_bus_write (write priority if read is also high), or to RADDR on slv_bus_read only, capturing addr, writedata and byteenable.
REQ-018 In the cycle after capture, WADDR SHALL raise awvalid and wvalid together; each SHALL drop independently on its own valid&ready; WADDR SHALL go to WRESP once both handshakes are done, including when both occur in the same cycle.
REQ-019 awaddr, wdata and wstrb SHALL stay stable while their valid is high.
REQ-020 RADDR SHALL raise arvalid the cycle after capture, drop it on arready, and go to RDATA.
REQ-021 bready SHALL be 1 in WRESP and IDLE; rready SHALL be 1 in RDATA and IDLE, so stray beats are drained and discarded.
REQ-022 WRESP SHALL accept bvalid only if bid == AXI_ID, latch bresp and go to DONE; beats with a mismatched ID SHALL be discarded.
REQ-023 RDATA SHALL accept rvalid only if rid == AXI_ID and rlast, latch rdata/rresp and go to DONE; beats with a mismatched ID SHALL be discarded.
REQ-024 DONE SHALL last 1 cycle with waitrequest 0, readdata/response valid, then return to IDLE.
REQ-025 waitrequest SHALL = (read|write) & state != DONE; it SHALL be 0 when no request is present.
REQ-026 The minimum latency from request to waitrequest low SHALL be 3 cycles, with ready and response tied high.
REQ-027 With TIMEOUT != 0, a counter SHALL clear on leaving IDLE and increment in every non-IDLE/DONE state.
REQ-028 When the counter reaches TIMEOUT, the FSM SHALL force DONE with response 2'b11 and readdata 0, and SHALL deassert awvalid/wvalid/arvalid.
REQ-029 If the master drops its request mid-transaction, the AXI transaction SHALL complete normally and the DONE result SHALL be discarded.
REQ-030 readdata and response SHALL hold their last value outside DONE.

Reset
REQ-031 On rst_n low, the FSM SHALL go to IDLE, all valids and the counter SHALL be 0, readdata/response/captured registers SHALL be 0, and waitrequest SHALL follow REQ-025.
REQ-032 Reset asserted mid-transaction SHALL abandon the transaction immediately; no AXI valid SHALL reassert until a new request arrives.

Verification
REQ-033 Write 0x1000 data 0xDEADBEEF be 0xF, ready/bvalid tied 1 -> awvalid+wvalid one cycle, DONE in cycle 3, response 00.
REQ-034 Write with awready delayed 4 cycles and wready immediate -> wvalid drops first, awvalid held 4 cycles, one B accepted, one DONE.
REQ-035 Read 0x2004, rdata 0x12345678, rresp 10 after 5 cycles -> readdata 0x12345678, response 10 during DONE.
REQ-036 Read and write high together in IDLE -> write issued first, no arvalid during the write.
REQ-037 TIMEOUT=8, bvalid never asserted -> DONE at count 8 with response 11, then a late bvalid is drained with no second DONE.
REQ-038 Read with rid != AXI_ID beat followed by a matching beat -> first beat discarded, second beat returned.
